// File: rtl/strela_exec_ctrl.sv
// strela_exec_ctrl: run-state FSM turning CSR command pulses into config/exec launches, completion flags and perf counters
module strela_exec_ctrl #(
    parameter int unsigned OUTPUT_NODES_NUM = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            load_configuration_i,
    input  logic                            start_execution_i,
    input  logic                            clear_cgra_i,
    input  logic [16*OUTPUT_NODES_NUM-1:0]  data_output_size_i,
    input  logic                            config_done_i,
    input  logic [OUTPUT_NODES_NUM-1:0]     output_done_i,
    input  logic                            stall_i,
    output logic                            config_start_o,
    output logic                            exec_start_o,
    output logic                            cgra_clear_o,
    output logic                            done_config_o,
    output logic                            done_exec_output_o,
    output logic [31:0]                     cycle_count_load_config_o,
    output logic [31:0]                     cycle_count_execute_o,
    output logic [31:0]                     cycle_count_stall_o
);
    typedef enum logic [1:0] {IDLE, CONFIG, EXEC} state_t;

    state_t                        state_q, state_d;
    logic [OUTPUT_NODES_NUM-1:0]   active_q, done_q, size_nz;
    logic                          exec_complete, cfg_start_d, exec_start_d, in_cfg, in_exec;
    logic [31:0]                   cnt_cfg, cnt_exec, cnt_stall;

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    for (genvar k = 0; k < OUTPUT_NODES_NUM; k++) begin : g_size
        assign size_nz[k] = |data_output_size_i[16*k +: 16];
    end

    // A node counts as finished if it already reported, reports now, or was never used.
    assign exec_complete = &(done_q | output_done_i | ~active_q);

    assign cycle_count_load_config_o = cnt_cfg;
    assign cycle_count_execute_o     = cnt_exec;
    assign cycle_count_stall_o       = cnt_stall;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: commands only accepted in IDLE, clear overrides everything
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = load_configuration_i ? CONFIG : start_execution_i ? EXEC : IDLE;
            CONFIG:  state_d = config_done_i ? IDLE : CONFIG;
            EXEC:    state_d = exec_complete ? IDLE : EXEC;
            default: state_d = IDLE;
        endcase
        if (clear_cgra_i) state_d = IDLE;
    end

    // Output decode: launch requests and per-state enables (load beats start, clear beats both)
    always_comb begin
        in_cfg       = (state_q == CONFIG);
        in_exec      = (state_q == EXEC);
        cfg_start_d  = (state_q == IDLE) && load_configuration_i && !clear_cgra_i;
        exec_start_d = (state_q == IDLE) && start_execution_i && !load_configuration_i && !clear_cgra_i;
    end

    // Launch pulses, sticky done flags, node masks and saturating counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            config_start_o     <= 1'b0;
            exec_start_o       <= 1'b0;
            cgra_clear_o       <= 1'b0;
            done_config_o      <= 1'b0;
            done_exec_output_o <= 1'b0;
            active_q           <= '0;
            done_q             <= '0;
            cnt_cfg            <= '0;
            cnt_exec           <= '0;
            cnt_stall          <= '0;
        end else begin
            config_start_o     <= cfg_start_d;
            exec_start_o       <= exec_start_d;
            cgra_clear_o       <= clear_cgra_i;
            done_config_o      <= (clear_cgra_i || cfg_start_d) ? 1'b0 :
                                  (in_cfg && config_done_i) ? 1'b1 : done_config_o;
            done_exec_output_o <= (clear_cgra_i || exec_start_d) ? 1'b0 :
                                  (in_exec && exec_complete) ? 1'b1 : done_exec_output_o;
            active_q           <= exec_start_d ? size_nz : active_q;
            done_q             <= exec_start_d ? '0 : in_exec ? (done_q | output_done_i) : done_q;
            cnt_cfg            <= cfg_start_d ? '0 : in_cfg ? sat_inc(cnt_cfg) : cnt_cfg;
            cnt_exec           <= exec_start_d ? '0 : in_exec ? sat_inc(cnt_exec) : cnt_exec;
            cnt_stall          <= exec_start_d ? '0 : (in_exec && stall_i) ? sat_inc(cnt_stall) : cnt_stall;
        end
    end
endmodule

// File: tb/tb_strela_exec_ctrl.sv
// tb_strela_exec_ctrl: directed and randomized checks of strela_exec_ctrl against a transaction-level model
module tb_strela_exec_ctrl;
    localparam int N = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              load_configuration_i = 1'b0;
    logic              start_execution_i = 1'b0;
    logic              clear_cgra_i = 1'b0;
    logic [16*N-1:0]   data_output_size_i = '0;
    logic              config_done_i = 1'b0;
    logic [N-1:0]      output_done_i = '0;
    logic              stall_i = 1'b0;
    logic              config_start_o, exec_start_o, cgra_clear_o, done_config_o, done_exec_output_o;
    logic [31:0]       cycle_count_load_config_o, cycle_count_execute_o, cycle_count_stall_o;

    int                tests = 0;
    int                fails = 0;
    int                tdone[N];
    logic [63:0]       stall_pat;

    strela_exec_ctrl #(.OUTPUT_NODES_NUM(N)) dut (
        .clk_i                     (clk_i),
        .rst_ni                    (rst_ni),
        .load_configuration_i      (load_configuration_i),
        .start_execution_i         (start_execution_i),
        .clear_cgra_i              (clear_cgra_i),
        .data_output_size_i        (data_output_size_i),
        .config_done_i             (config_done_i),
        .output_done_i             (output_done_i),
        .stall_i                   (stall_i),
        .config_start_o            (config_start_o),
        .exec_start_o              (exec_start_o),
        .cgra_clear_o              (cgra_clear_o),
        .done_config_o             (done_config_o),
        .done_exec_output_o        (done_exec_output_o),
        .cycle_count_load_config_o (cycle_count_load_config_o),
        .cycle_count_execute_o     (cycle_count_execute_o),
        .cycle_count_stall_o       (cycle_count_stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pulses"}, {29'd0, config_start_o, exec_start_o, cgra_clear_o}, 0);
        check({tag, "_flags"}, {30'd0, done_config_o, done_exec_output_o}, 0);
        check({tag, "_cnt_cfg"}, cycle_count_load_config_o, 0);
        check({tag, "_cnt_exec"}, cycle_count_execute_o, 0);
        check({tag, "_cnt_stall"}, cycle_count_stall_o, 0);
    endtask

    // Config load: done arrives in config cycle len (cycle 1 carries config_start_o)
    task automatic run_cfg(input int len, input bit level, input bit with_start, input bit noise);
        int extra = 0;
        load_configuration_i = 1'b1;
        start_execution_i = with_start;
        tick();
        load_configuration_i = 1'b0;
        start_execution_i = 1'b0;
        check("cfg_start_pulse", config_start_o, 1);
        check("cfg_no_exec_start", exec_start_o, 0);
        check("cfg_done_cleared", done_config_o, 0);
        for (int k = 1; k <= len; k++) begin
            config_done_i = level ? (k >= len) : (k == len);
            start_execution_i = noise & 1'($urandom_range(0, 1));
            output_done_i = N'($urandom);
            tick();
            extra += int'(config_start_o) + int'(exec_start_o);
        end
        config_done_i = 1'b0;
        start_execution_i = 1'b0;
        output_done_i = '0;
        check("cfg_done", done_config_o, 1);
        check("cfg_count", cycle_count_load_config_o, len);
        check("cfg_extra_pulses", extra, 0);
    endtask

    // Execution: model says completion at the latest active node's done cycle (1 if none active)
    task automatic run_exec(input logic [16*N-1:0] sz, input bit level, input bit noise);
        int c = 1;
        int exp_stall = 0;
        int early = 0;
        int extra = 0;
        logic [N-1:0] act;
        for (int j = 0; j < N; j++) begin
            act[j] = (sz[16*j +: 16] != 16'd0);
            if (act[j] && tdone[j] > c) c = tdone[j];
        end
        for (int i = 1; i <= c; i++) exp_stall += int'(stall_pat[i]);
        data_output_size_i = sz;
        start_execution_i = 1'b1;
        tick();
        start_execution_i = 1'b0;
        data_output_size_i = 16*N'($urandom);
        check("exec_start_pulse", exec_start_o, 1);
        check("exec_done_cleared", done_exec_output_o, 0);
        for (int k = 1; k <= c; k++) begin
            for (int j = 0; j < N; j++)
                output_done_i[j] = act[j] ? (level ? (k >= tdone[j]) : (k == tdone[j])) : 1'($urandom_range(0, 1));
            stall_i = stall_pat[k];
            load_configuration_i = noise & 1'($urandom_range(0, 1));
            start_execution_i = noise & 1'($urandom_range(0, 1));
            tick();
            if (k < c) early += int'(done_exec_output_o);
            extra += int'(config_start_o) + int'(exec_start_o);
        end
        output_done_i = '0;
        stall_i = 1'b0;
        load_configuration_i = 1'b0;
        start_execution_i = 1'b0;
        check("exec_done", done_exec_output_o, 1);
        check("exec_count", cycle_count_execute_o, c);
        check("exec_stall", cycle_count_stall_o, exp_stall);
        check("exec_early_done", early, 0);
        check("exec_extra_pulses", extra, 0);
    endtask

    initial begin
        #3;
        check_all_zero("reset");
        #9 rst_ni = 1'b1;
        tick();
        check_all_zero("idle_after_reset");

        run_cfg(20, 1'b0, 1'b0, 1'b0);

        tdone = '{12, 30, 0, 0};
        stall_pat = 64'h0000_0000_0000_00E0;
        run_exec({16'd0, 16'd0, 16'd16, 16'd80}, 1'b0, 1'b0);
        check("cfg_flag_kept", done_config_o, 1);

        tdone = '{0, 0, 0, 0};
        stall_pat = 64'h2;
        run_exec('0, 1'b0, 1'b0);

        // Clear in EXEC cycle 7
        tdone = '{50, 50, 50, 50};
        data_output_size_i = {4{16'd8}};
        start_execution_i = 1'b1;
        tick();
        start_execution_i = 1'b0;
        for (int k = 1; k < 7; k++) tick();
        clear_cgra_i = 1'b1;
        load_configuration_i = 1'b1;
        tick();
        clear_cgra_i = 1'b0;
        load_configuration_i = 1'b0;
        check("clear_pulse", cgra_clear_o, 1);
        check("clear_flags", {done_config_o, done_exec_output_o}, 0);
        check("clear_exec_hold", cycle_count_execute_o, 7);
        tick();
        check("clear_pulse_end", cgra_clear_o, 0);
        check("clear_exec_still", cycle_count_execute_o, 7);

        // Clear beats load in IDLE
        clear_cgra_i = 1'b1;
        load_configuration_i = 1'b1;
        tick();
        clear_cgra_i = 1'b0;
        load_configuration_i = 1'b0;
        check("clear_beats_load", config_start_o, 0);
        tick();
        check("idle_stays", {config_start_o, exec_start_o}, 0);

        run_cfg(5, 1'b1, 1'b1, 1'b1);

        for (int r = 0; r < 24; r++) begin
            logic [16*N-1:0] sz;
            for (int j = 0; j < N; j++) begin
                sz[16*j +: 16] = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
                tdone[j] = $urandom_range(1, 40);
            end
            stall_pat = {$urandom, $urandom};
            if (r % 3 == 0) run_cfg($urandom_range(1, 30), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            else            run_exec(sz, 1'($urandom_range(0, 1)), 1'b1);
            for (int w = $urandom_range(0, 3); w > 0; w--) tick();
        end

        // Saturation of the execute counter
        tdone = '{0, 0, 0, 900};
        data_output_size_i = {16'd4, 48'd0};
        start_execution_i = 1'b1;
        tick();
        start_execution_i = 1'b0;
        tick();
        dut.cnt_exec = 32'hFFFF_FFFE;
        tick();
        tick();
        tick();
        check("sat_hold", cycle_count_execute_o, 32'hFFFF_FFFF);
        check("sat_still_running", done_exec_output_o, 0);

        // Async reset mid-EXEC
        stall_i = 1'b1;
        tick();
        #2 rst_ni = 1'b0;
        #1;
        check_all_zero("async_reset");
        stall_i = 1'b0;
        #3 rst_ni = 1'b1;
        tick();
        check_all_zero("after_async_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
